// File: rtl/bus_arbiter4.sv
// bus_arbiter4: four-requester round-robin arbiter for one shared 16-bit bus.
// An owner keeps the bus for at most MAX_BURST consecutive transfers while
// someone else is waiting. A lone requester keeps it indefinitely. Every
// output is registered, so req and data reach the outputs only at clock edges.
module bus_arbiter4 #(
    parameter int MAX_BURST = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  req,
    input  logic [15:0] in1,
    input  logic [15:0] in2,
    input  logic [15:0] in3,
    input  logic [15:0] in4,
    output logic [3:0]  grant,
    output logic [1:0]  control,
    output logic [15:0] bus_out,
    output logic        bus_valid
);

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    state_t      state_reg;
    logic [1:0]  last_owner_reg;
    logic [2:0]  burst_cnt_reg;

    logic [15:0] in_data [4];
    logic [1:0]  rot_idx [4];
    logic [3:0]  req_rot;
    logic        win_found;
    logic [1:0]  win_idx;
    logic        transfer;
    logic        burst_done;

    assign in_data[0] = in1;
    assign in_data[1] = in2;
    assign in_data[2] = in3;
    assign in_data[3] = in4;

    // Requests in search order. Slot 0 is last_owner+1, and slot 3 wraps back
    // to last_owner itself, so a lone requester can win again.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_rot
            assign rot_idx[gi] = last_owner_reg + 2'(gi + 1);
            assign req_rot[gi] = req[rot_idx[gi]];
        end
    endgenerate

    // Pick the first set request in rotation order (the lowest slot wins).
    always_comb begin
        win_found = 1'b0;
        win_idx   = last_owner_reg;
        for (int k = 3; k >= 0; k--) begin
            if (req_rot[k]) begin
                win_found = 1'b1;
                win_idx   = rot_idx[k];
            end
        end
    end

    // A transfer happens when the granted requester is still requesting.
    // burst_done means this cycle's transfer is the MAX_BURST-th one.
    assign transfer   = |(grant & req);
    assign burst_done = (burst_cnt_reg == 3'(MAX_BURST - 1));

    // Arbitration state machine with registered grant, select and data outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg      <= IDLE;
            grant          <= 4'b0000;
            control        <= 2'd0;
            bus_out        <= 16'h0000;
            bus_valid      <= 1'b0;
            burst_cnt_reg  <= 3'd0;
            last_owner_reg <= 2'd3;
        end else begin
            bus_valid <= transfer;
            if (transfer) begin
                bus_out <= in_data[control];
            end

            case (state_reg)
                IDLE: begin
                    burst_cnt_reg <= 3'd0;
                    if (win_found) begin
                        state_reg      <= OWN;
                        grant          <= 4'b0001 << win_idx;
                        control        <= win_idx;
                        last_owner_reg <= win_idx;
                    end
                end
                OWN: begin
                    if (!req[control]) begin
                        // The owner has dropped its request. Hand the bus over
                        // directly, or go idle if nobody else is requesting.
                        burst_cnt_reg <= 3'd0;
                        if (win_found) begin
                            grant          <= 4'b0001 << win_idx;
                            control        <= win_idx;
                            last_owner_reg <= win_idx;
                        end else begin
                            state_reg <= IDLE;
                            grant     <= 4'b0000;
                        end
                    end else if (burst_done) begin
                        // The burst limit is reached. Hand over only if
                        // another requester is waiting; otherwise start a
                        // new burst for the same owner.
                        burst_cnt_reg <= 3'd0;
                        if (|(req & ~grant)) begin
                            grant          <= 4'b0001 << win_idx;
                            control        <= win_idx;
                            last_owner_reg <= win_idx;
                        end
                    end else begin
                        burst_cnt_reg <= burst_cnt_reg + 3'd1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    grant     <= 4'b0000;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter4.sv
// tb_bus_arbiter4: directed scenarios followed by random traffic. Every cycle
// is compared against a transfer-level reference model of the arbiter.
module tb_bus_arbiter4;

    localparam int MB = 4;

    logic        clock;
    logic        reset;
    logic [3:0]  req;
    logic [15:0] in1, in2, in3, in4;
    logic [3:0]  grant;
    logic [1:0]  control;
    logic [15:0] bus_out;
    logic        bus_valid;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model state. m_owner is -1 when nobody owns the bus.
    int          m_owner;
    int          m_last;
    int          m_xfers;
    int          m_ctrl;
    logic [15:0] m_bus;
    logic        m_valid;

    bus_arbiter4 #(.MAX_BURST(MB)) dut (
        .clock     (clock),
        .reset     (reset),
        .req       (req),
        .in1       (in1),
        .in2       (in2),
        .in3       (in3),
        .in4       (in4),
        .grant     (grant),
        .control   (control),
        .bus_out   (bus_out),
        .bus_valid (bus_valid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    // Advance the model by one clock edge, using the inputs currently applied.
    task automatic model_edge();
        logic [15:0] d [4];
        int pick;
        bit others;
        d[0] = in1; d[1] = in2; d[2] = in3; d[3] = in4;
        if (reset) begin
            m_owner = -1; m_last = 3; m_xfers = 0; m_ctrl = 0;
            m_bus = 16'h0000; m_valid = 1'b0;
            return;
        end
        // Round-robin search starting just after the last owner.
        pick = -1;
        for (int j = 1; j <= 4; j++) begin
            if (pick < 0 && req[(m_last + j) % 4]) pick = (m_last + j) % 4;
        end
        m_valid = (m_owner >= 0) && req[m_owner];
        if (m_valid) m_bus = d[m_owner];
        if (m_owner < 0) begin
            if (pick >= 0) begin
                m_owner = pick; m_last = pick; m_ctrl = pick; m_xfers = 0;
            end
        end else if (!req[m_owner]) begin
            m_xfers = 0;
            if (pick >= 0) begin
                m_owner = pick; m_last = pick; m_ctrl = pick;
            end else begin
                m_owner = -1;
            end
        end else begin
            others = 0;
            for (int i = 0; i < 4; i++) if (i != m_owner && req[i]) others = 1;
            m_xfers = m_xfers + 1;
            if (m_xfers >= MB) begin
                m_xfers = 0;
                if (others) begin
                    m_owner = pick; m_last = pick; m_ctrl = pick;
                end
            end
        end
    endtask

    // One clock cycle: apply inputs, clock, then compare against the model.
    task automatic step(input logic rst, input logic [3:0] rq);
        logic [3:0] eg;
        reset = rst;
        req   = rq;
        model_edge();
        @(posedge clock);
        #1;
        cyc++;
        eg = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
        chk("model_grant",   32'(grant),     32'(eg));
        chk("model_control", 32'(control),   32'(m_ctrl));
        chk("model_bus_out", 32'(bus_out),   32'(m_bus));
        chk("model_valid",   32'(bus_valid), 32'(m_valid));
        $display("cyc=%0d rst=%0b req=%b grant=%b ctrl=%0d bus=%h valid=%0b",
                 cyc, rst, rq, grant, control, bus_out, bus_valid);
    endtask

    initial begin
        int vcount;
        logic [15:0] held;
        reset = 1'b1; req = 4'b0000;
        in1 = 16'h1234; in2 = 16'h2222; in3 = 16'h3333; in4 = 16'h4444;

        // Reset state.
        step(1'b1, 4'b0000);
        step(1'b1, 4'b1111);
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_control", 32'(control), 32'h0);
        chk("rst_bus", 32'(bus_out), 32'h0);
        chk("rst_valid", 32'(bus_valid), 32'h0);

        // Single requester: grant one edge after req, data on the next edge.
        step(1'b0, 4'b0001);
        chk("single_grant", 32'(grant), 32'h1);
        chk("single_novalid", 32'(bus_valid), 32'h0);
        step(1'b0, 4'b0001);
        chk("single_bus", 32'(bus_out), 32'h1234);
        chk("single_valid", 32'(bus_valid), 32'h1);
        step(1'b0, 4'b0001);
        chk("single_valid2", 32'(bus_valid), 32'h1);

        // Full contention: owners 0,1,2,3,0 in turn, 4 cycles each, no gap.
        step(1'b1, 4'b0000);
        for (int k = 1; k <= 17; k++) begin
            step(1'b0, 4'b1111);
            chk("rr_grant", 32'(grant), 32'(1 << (((k - 1) / MB) % 4)));
            chk("rr_control", 32'(control), 32'(((k - 1) / MB) % 4));
        end

        // Sole requester at the burst limit keeps the bus.
        step(1'b1, 4'b0000);
        vcount = 0;
        for (int k = 1; k <= 10; k++) begin
            step(1'b0, 4'b0100);
            chk("sole_grant", 32'(grant), 32'h4);
            if (bus_valid) vcount++;
        end
        step(1'b0, 4'b0000);
        if (bus_valid) vcount++;
        chk("sole_pulses", 32'(vcount), 32'd9);

        // Early release: owner 1 drops after 2 transfers while requester 3 waits.
        step(1'b1, 4'b0000);
        step(1'b0, 4'b0010);
        chk("early_grant1", 32'(grant), 32'h2);
        step(1'b0, 4'b0010);
        step(1'b0, 4'b0010);
        step(1'b0, 4'b1000);
        chk("early_grant3", 32'(grant), 32'h8);
        chk("early_control", 32'(control), 32'h3);

        // Reset during the 3rd transfer of owner 2.
        step(1'b1, 4'b0000);
        step(1'b0, 4'b0100);
        step(1'b0, 4'b0100);
        step(1'b0, 4'b0100);
        step(1'b1, 4'b0100);
        chk("midrst_grant", 32'(grant), 32'h0);
        chk("midrst_valid", 32'(bus_valid), 32'h0);
        chk("midrst_bus", 32'(bus_out), 32'h0);
        step(1'b0, 4'b1111);
        chk("midrst_first", 32'(grant), 32'h1);

        // Return to idle: control and bus_out hold their values.
        step(1'b1, 4'b0000);
        step(1'b0, 4'b0100);
        step(1'b0, 4'b0100);
        held = bus_out;
        step(1'b0, 4'b0000);
        chk("idle_grant", 32'(grant), 32'h0);
        chk("idle_control", 32'(control), 32'h2);
        chk("idle_valid", 32'(bus_valid), 32'h0);
        chk("idle_bus", 32'(bus_out), 32'(held));
        chk("idle_bus_val", 32'(held), 32'h3333);

        // Random traffic with sticky requests and occasional resets.
        begin
            logic [3:0] rq;
            rq = 4'b0000;
            for (int n = 0; n < 400; n++) begin
                in1 = 16'($urandom); in2 = 16'($urandom);
                in3 = 16'($urandom); in4 = 16'($urandom);
                if ($urandom_range(0, 3) == 0) rq = 4'($urandom);
                step(($urandom_range(0, 59) == 0), rq);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_arbiter4.md
BUS_ARBITER4 -- requirements
Module: bus_arbiter4

Interface
REQ-001 The block SHALL have parameter MAX_BURST, default 4, giving the maximum consecutive transfers per grant when another requester waits; legal range 1..7.
REQ-002 The block SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset, sampled on the rising edge of clock.
REQ-004 The block SHALL have port req, input, 4 bits: req[i] high means requester i wants the shared 16-bit bus.
REQ-005 The block SHALL have ports in1, in2, in3, in4, input, 16 bits each: data of requesters 0..3 respectively.
REQ-006 The block SHALL have port grant, output, 4 bits: registered, one-hot or zero, current bus owner.
REQ-007 The block SHALL have port control, output, 2 bits: registered, encoded owner index, driving the shared 4:1 mux select.
REQ-008 The block SHALL have port bus_out, output, 16 bits: registered transferred word.
REQ-009 The block SHALL have port bus_valid, output, 1 bit: high for exactly the cycle after each transfer.

Function
REQ-010 The block SHALL implement two states, IDLE (grant=0000) and OWN (exactly one grant bit set).
REQ-011 A transfer SHALL occur in any cycle where grant[i]=1 and req[i]=1.
REQ-012 On the edge ending a transfer cycle, bus_out SHALL load in(i+1) of owner i and bus_valid SHALL be set to 1.
REQ-013 In all other cycles bus_out SHALL hold and bus_valid SHALL be set to 0.
REQ-014 Arbitration SHALL be round-robin: the search starts at (last_owner+1) mod 4 and picks the first set req bit, wrapping 3->0.
REQ-015 In IDLE with any req bit set, the next edge SHALL enter OWN with grant and control set to the winner, so grant follows req by 1 cycle.
REQ-016 The burst counter SHALL count transfers of the current owner, saturate at MAX_BURST, and clear on every ownership change.
REQ-017 In OWN, the owner SHALL be released on the edge where req[owner]=0, or where the counter has reached MAX_BURST and another req bit is set.
REQ-018 On release, if any other req bit is set, ownership SHALL pass directly to the round-robin winner after the current owner, with no IDLE cycle between owners; otherwise the state SHALL go to IDLE.
REQ-019 When the counter reaches MAX_BURST and no other requester waits, the owner SHALL keep the grant and the counter SHALL restart at 0.
REQ-020 A requester released because its req dropped SHALL NOT be regranted before the rotation passes it, unless it is the only requester.
REQ-021 last_owner SHALL update on every grant and hold in IDLE.
REQ-022 control SHALL equal the index of the set grant bit while in OWN and SHALL hold its last value in IDLE.
REQ-023 Changes to req and in1..in4 SHALL affect outputs only at clock edges, with no combinational path to any output.

Reset
REQ-024 While reset=1 at an edge, the block SHALL set grant=0000, control=00, bus_out=0x0000, bus_valid=0, the counter to 0, last_owner=3 and the state to IDLE, regardless of req.
REQ-025 A reset arriving mid-burst SHALL abort the transfer in that cycle, so bus_valid=0 after that edge.
REQ-026 After reset deasserts, requester 0 SHALL have first priority.

Verification
REQ-027 Single requester: after reset, req=0001, in1=0x1234 -> grant=0001 one edge later, bus_out=0x1234 and bus_valid=1 on the following edge, repeating while req is held.
REQ-028 Contention: req=1111 held, MAX_BURST=4 -> owners 0,1,2,3,0 in turn, each granted exactly 4 transfers, no idle gap, control tracking 0,1,2,3,0.
REQ-029 Sole requester at burst limit: req=0100 for 10 cycles -> grant stays 0100 throughout, with 9 consecutive bus_valid pulses.
REQ-030 Early release: owner 1 drops req after 2 transfers while req[3]=1 -> next edge grant=1000 (requester 2 skipped), counter cleared.
REQ-031 Reset mid-burst: reset=1 during the 3rd transfer of owner 2 -> after that edge all outputs are at reset values; with req=1111 after reset, requester 0 is granted first.
REQ-032 Idle return: all req drop in OWN -> grant=0000, control holds, bus_valid=0 one edge later, bus_out unchanged.
